uart_ctrl: RTL and testbench
============================

UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 SHALL have parameter TX_FIFO_DEPTH, default 4, TX byte FIFO entries (power of 2, >=2).
REQ-002 SHALL have ports:
- sysclk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- addr  in  2  register select: 0=TXD, 1=RXD, 2=CON.
- rd  in  1  CPU read strobe, one cycle.
- wr  in  1  CPU write strobe, one cycle.
- wdata  in  32  write data.
- rdata  out  32  read data.
- irq  out  1  interrupt request, level.
- tx_data  out  8  byte to UART sender.
- tx_start  out  1  one-cycle start pulse to UART sender.
- tx_status  in  1  sender idle (1) / busy (0).
- rx_data  in  8  received byte.
- rx_status  in  1  receiver byte-ready pulse.

Function
REQ-003 SHALL register rdata one cycle after rd; addr is sampled with rd; rdata holds until the next rd.
REQ-004 SHALL push wdata[7:0] into the TX FIFO on wr to TXD; when full, SHALL drop the byte and set sticky tx_ovf.
REQ-005 SHALL pop before push within a cycle, so a write to a full FIFO accepted in a pop cycle is not dropped.
REQ-006 SHALL keep FIFO count 0..TX_FIFO_DEPTH at $clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
REQ-007 SHALL run TX FSM states IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-008 IDLE->START when FIFO non-empty and tx_status=1: pop head into tx_data register.
REQ-009 START SHALL assert tx_start for exactly one cycle, then ->WAIT_BUSY.
REQ-010 WAIT_BUSY->WAIT_DONE on tx_status=0; WAIT_DONE->IDLE on tx_status=1.
REQ-011 SHALL hold tx_data stable from START until the return to IDLE.
REQ-012 SHALL detect the rx_status rising edge; on an edge, capture rx_data into rx_buf and set rx_valid.
REQ-013 An edge while rx_valid=1 SHALL overwrite rx_buf and set sticky rx_ovr.
REQ-014 rd of RXD SHALL return {24'b0,rx_buf} and clear rx_valid.
REQ-015 When an RXD read and an rx edge coincide, the new byte wins: rx_valid stays 1, no rx_ovr.
REQ-016 CON layout:
- [0] tx_irq_en RW.
- [1] rx_irq_en RW.
- [2] rx_valid RO.
- [3] tx_idle RO (FIFO empty and FSM IDLE).
- [4] tx_full RO.
- [5] rx_ovr W1C.
- [6] tx_ovf W1C.
- Other bits read 0.
REQ-017 A rd of TXD SHALL return 0; a wr to RXD SHALL be ignored.
REQ-018 SHALL drive irq = (rx_irq_en & rx_valid) | (tx_irq_en & tx_idle), registered.

Reset
REQ-019 While reset=0, SHALL clear the FIFO, place the FSM in IDLE, and clear all CON bits, rx_buf, rx_valid, rdata, tx_data, tx_start and irq.
REQ-020 Reset mid-transfer SHALL abandon the byte and FIFO contents; no tx_start follows release until a new push.

Configuration
REQ-021 SHALL use macro UART_CTRL_IRQ_EN.
- Defined: CON[1:0] and irq behave as in REQ-016/REQ-018.
- Undefined: CON[1:0] read 0, writes are ignored, irq is constant 0, and no irq logic exists.

Structure
REQ-022 Package uart_ctrl_pkg SHALL hold the register offsets, CON bit positions and the TX FSM state enum.
REQ-023 FIFO SHALL be sub-module uart_ctrl_fifo (push, pop, full, empty, count); all other logic is in uart_ctrl.

Verification
REQ-024 Push 0x55, 0xA3 with tx_status modelled as busy for 10 cycles -> two tx_start pulses in order, tx_data 0x55 then 0xA3, CON[3]=1 after the second byte.
REQ-025 Five pushes with DEPTH=4 and sender held busy -> fifth byte dropped, CON[6]=1, CON[4]=1; writing 0x40 to CON clears bit 6.
REQ-026 rx pulse with 0x3C, then rd RXD -> rdata=0x3C, CON[2] goes 1 then 0.
REQ-027 Two rx pulses (0x11, 0x22) without a read -> RXD=0x22 and CON[5]=1; RXD read in the same cycle as a pulse -> CON[2] stays 1.
REQ-028 With UART_CTRL_IRQ_EN, write CON=0x2 then rx pulse -> irq=1; RXD read -> irq=0. Without the macro -> irq stays 0.
REQ-029 Assert reset in WAIT_DONE with 2 bytes queued -> FIFO empty, CON=0x08, no further tx_start.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: register offsets, CON bit positions and TX FSM states for uart_ctrl.
package uart_ctrl_pkg;

    localparam logic [1:0] ADDR_TXD = 2'd0;
    localparam logic [1:0] ADDR_RXD = 2'd1;
    localparam logic [1:0] ADDR_CON = 2'd2;

    localparam int CON_TX_IRQ_EN = 0;
    localparam int CON_RX_IRQ_EN = 1;
    localparam int CON_RX_VALID  = 2;
    localparam int CON_TX_IDLE   = 3;
    localparam int CON_TX_FULL   = 4;
    localparam int CON_RX_OVR    = 5;
    localparam int CON_TX_OVF    = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } tx_state_e;

endpackage

// File: rtl/uart_ctrl_fifo.sv
// uart_ctrl_fifo: TX byte FIFO; a pop frees its slot for a push in the same cycle.
module uart_ctrl_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          sysclk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge sysclk or negedge reset)
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end

    always_ff @(posedge sysclk)
        if (do_push) mem_q[wr_ptr_q] <= din;

endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: CPU register front-end for a UART sender/receiver with a TX FIFO.
// Interrupt enables and irq exist only when UART_CTRL_IRQ_EN is defined.
module uart_ctrl #(
    parameter int TX_FIFO_DEPTH = 4
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_status,
    input  logic [7:0]  rx_data,
    input  logic        rx_status
);
    import uart_ctrl_pkg::*;

    localparam int AW = $clog2(TX_FIFO_DEPTH);

    tx_state_e   state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d, rx_buf_q, rx_buf_d, fifo_dout;
    logic [31:0] rdata_q, rdata_d, con_rd;
    logic        tx_start_q, tx_start_d, rx_valid_q, rx_valid_d, rx_stat_q;
    logic        rx_ovr_q, rx_ovr_d, tx_ovf_q, tx_ovf_d;
    logic        push, pop, con_wr, rd_rxd, rx_edge, tx_idle;
    logic        fifo_full, fifo_empty, tx_irq_en, rx_irq_en;
    logic [AW:0] fifo_count;
    logic        unused_ok;

    assign unused_ok = ^{wdata, fifo_count};
    assign rdata     = rdata_q;
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;

    uart_ctrl_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_fifo (
        .sysclk (sysclk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .din    (wdata[7:0]),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

`ifdef UART_CTRL_IRQ_EN
    logic tx_irq_en_q, rx_irq_en_q, irq_q;
    assign tx_irq_en = tx_irq_en_q;
    assign rx_irq_en = rx_irq_en_q;
    assign irq       = irq_q;

    always_ff @(posedge sysclk or negedge reset)
        if (!reset) begin
            tx_irq_en_q <= 1'b0;
            rx_irq_en_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (con_wr) begin
                tx_irq_en_q <= wdata[CON_TX_IRQ_EN];
                rx_irq_en_q <= wdata[CON_RX_IRQ_EN];
            end
            irq_q <= (rx_irq_en_q & rx_valid_q) | (tx_irq_en_q & tx_idle);
        end
`else
    assign tx_irq_en = 1'b0;
    assign rx_irq_en = 1'b0;
    assign irq       = 1'b0;
`endif

    always_comb begin
        push    = wr & (addr == ADDR_TXD);
        con_wr  = wr & (addr == ADDR_CON);
        rd_rxd  = rd & (addr == ADDR_RXD);
        rx_edge = rx_status & ~rx_stat_q;
        tx_idle = fifo_empty & (state_q == ST_IDLE);
        pop     = (state_q == ST_IDLE) & ~fifo_empty & tx_status;
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      if (pop) state_d = ST_START;
            ST_START:     state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (!tx_status) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (tx_status) state_d = ST_IDLE;
        endcase
        tx_data_d  = pop ? fifo_dout : tx_data_q;
        tx_start_d = state_d == ST_START;
        // A new byte arriving on the same edge as an RXD read keeps rx_valid set.
        rx_buf_d   = rx_edge ? rx_data : rx_buf_q;
        rx_valid_d = rx_edge | (rx_valid_q & ~rd_rxd);
        rx_ovr_d   = (rx_edge & rx_valid_q & ~rd_rxd) | (rx_ovr_q & ~(con_wr & wdata[CON_RX_OVR]));
        tx_ovf_d   = (push & fifo_full & ~pop) | (tx_ovf_q & ~(con_wr & wdata[CON_TX_OVF]));
        con_rd                = '0;
        con_rd[CON_TX_IRQ_EN] = tx_irq_en;
        con_rd[CON_RX_IRQ_EN] = rx_irq_en;
        con_rd[CON_RX_VALID]  = rx_valid_q;
        con_rd[CON_TX_IDLE]   = tx_idle;
        con_rd[CON_TX_FULL]   = fifo_full;
        con_rd[CON_RX_OVR]    = rx_ovr_q;
        con_rd[CON_TX_OVF]    = tx_ovf_q;
        rdata_d = !rd ? rdata_q :
                  addr == ADDR_RXD ? {24'b0, rx_buf_q} :
                  addr == ADDR_CON ? con_rd : '0;
    end

    always_ff @(posedge sysclk or negedge reset)
        if (!reset) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            rx_buf_q   <= '0;
            rx_valid_q <= 1'b0;
            rx_stat_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
            tx_ovf_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            rx_buf_q   <= rx_buf_d;
            rx_valid_q <= rx_valid_d;
            rx_stat_q  <= rx_status;
            rx_ovr_q   <= rx_ovr_d;
            tx_ovf_q   <= tx_ovf_d;
            rdata_q    <= rdata_d;
        end

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed self-checking bench for uart_ctrl with a simple busy-for-10-cycles sender.
module tb_uart_ctrl;
    import uart_ctrl_pkg::*;

    logic        sysclk = 1'b0, reset = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [1:0]  addr = '0;
    logic [31:0] wdata = '0, rdata;
    logic        irq, tx_start, tx_status, rx_status = 1'b0, hold_busy = 1'b0;
    logic [7:0]  tx_data, rx_data = '0;
    logic [7:0]  log_q [16];
    int          checks = 0, failures = 0, sent = 0, busy_cnt = 0;

    uart_ctrl #(.TX_FIFO_DEPTH(4)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .addr      (addr),
        .rd        (rd),
        .wr        (wr),
        .wdata     (wdata),
        .rdata     (rdata),
        .irq       (irq),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_status (tx_status),
        .rx_data   (rx_data),
        .rx_status (rx_status)
    );

    always #5 sysclk = ~sysclk;

    assign tx_status = !hold_busy && busy_cnt == 0;

    always @(posedge sysclk) begin
        if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        if (tx_start) begin
            busy_cnt <= 10;
            if (sent < 16) log_q[sent] <= tx_data;
            sent <= sent + 1;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
        addr = a; rd = 1'b1;
        tick();
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rx_data = d; rx_status = 1'b1;
        tick();
        rx_status = 1'b0;
        tick();
    endtask

    task automatic wait_sent(input int target, input int budget);
        int k = 0;
        while (sent < target && k < budget) begin
            tick();
            k++;
        end
        check("wait_sent", 32'(sent), 32'(target));
    endtask

    initial begin
        logic [31:0] d;
        tick(2);
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_tx_start", 32'(tx_start), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        reset = 1'b1;
        tick();
        rd_reg(ADDR_CON, d); check("con_after_reset", d, 32'h08);
        rd_reg(ADDR_TXD, d); check("txd_read_zero", d, 32'h0);

        wr_reg(ADDR_TXD, 32'h55);
        wr_reg(ADDR_TXD, 32'hA3);
        wait_sent(1, 50);
        tick(3);
        check("tx_data_hold", 32'(tx_data), 32'h55);
        wait_sent(2, 50);
        tick(15);
        check("tx_byte0", 32'(log_q[0]), 32'h55);
        check("tx_byte1", 32'(log_q[1]), 32'hA3);
        check("tx_pulse_count", 32'(sent), 32'd2);
        rd_reg(ADDR_CON, d); check("con_idle_after_tx", d, 32'h08);

        hold_busy = 1'b1;
        for (int i = 1; i <= 5; i++) wr_reg(ADDR_TXD, 32'(i));
        rd_reg(ADDR_CON, d); check("con_full_ovf", d, 32'h50);
        wr_reg(ADDR_CON, 32'h40);
        rd_reg(ADDR_CON, d); check("con_ovf_cleared", d, 32'h10);
        hold_busy = 1'b0;
        wr_reg(ADDR_TXD, 32'h06);
        wait_sent(7, 200);
        tick(15);
        check("drain0", 32'(log_q[2]), 32'h01);
        check("drain1", 32'(log_q[3]), 32'h02);
        check("drain2", 32'(log_q[4]), 32'h03);
        check("drain3", 32'(log_q[5]), 32'h04);
        check("drain_popcycle_push", 32'(log_q[6]), 32'h06);
        rd_reg(ADDR_CON, d); check("con_no_ovf_on_pop_push", d, 32'h08);

        rx_pulse(8'h3C);
        rd_reg(ADDR_CON, d); check("con_rx_valid", d, 32'h0C);
        rd_reg(ADDR_RXD, d); check("rxd_3c", d, 32'h3C);
        rd_reg(ADDR_CON, d); check("con_rx_cleared", d, 32'h08);

        rx_pulse(8'h11);
        rx_pulse(8'h22);
        rd_reg(ADDR_CON, d); check("con_rx_ovr", d, 32'h2C);
        rd_reg(ADDR_RXD, d); check("rxd_overwrite", d, 32'h22);
        rd_reg(ADDR_CON, d); check("con_ovr_sticky", d, 32'h28);
        wr_reg(ADDR_CON, 32'h20);
        rd_reg(ADDR_CON, d); check("con_ovr_cleared", d, 32'h08);

        rx_pulse(8'h33);
        addr = ADDR_RXD; rd = 1'b1; rx_data = 8'h44; rx_status = 1'b1;
        tick();
        rd = 1'b0; rx_status = 1'b0;
        check("rxd_coincide_old", rdata, 32'h33);
        tick();
        rd_reg(ADDR_CON, d); check("con_coincide", d, 32'h0C);
        rd_reg(ADDR_RXD, d); check("rxd_new_wins", d, 32'h44);
        rd_reg(ADDR_CON, d); check("con_after_new", d, 32'h08);

`ifdef UART_CTRL_IRQ_EN
        wr_reg(ADDR_CON, 32'h2);
        rd_reg(ADDR_CON, d); check("con_rx_irq_en", d, 32'h0A);
        check("irq_idle_low", 32'(irq), 32'h0);
        rx_pulse(8'h5A);
        tick();
        check("irq_rx_high", 32'(irq), 32'h1);
        rd_reg(ADDR_RXD, d); check("rxd_5a", d, 32'h5A);
        tick();
        check("irq_rx_low", 32'(irq), 32'h0);
        wr_reg(ADDR_CON, 32'h1);
        tick();
        check("irq_tx_idle", 32'(irq), 32'h1);
        wr_reg(ADDR_CON, 32'h0);
        tick();
        check("irq_tx_off", 32'(irq), 32'h0);
`else
        wr_reg(ADDR_CON, 32'h3);
        rd_reg(ADDR_CON, d); check("con_en_ignored", d, 32'h08);
        rx_pulse(8'h5A);
        tick();
        check("irq_const_low", 32'(irq), 32'h0);
        rd_reg(ADDR_RXD, d); check("rxd_5a", d, 32'h5A);
        check("irq_const_low2", 32'(irq), 32'h0);
`endif

        wr_reg(ADDR_TXD, 32'h71);
        wr_reg(ADDR_TXD, 32'h72);
        wr_reg(ADDR_TXD, 32'h73);
        wait_sent(8, 50);
        rd_reg(ADDR_CON, d); check("con_busy_queued", d, 32'h00);
        tick(2);
        reset = 1'b0;
        #1;
        check("mid_rst_tx_start", 32'(tx_start), 32'h0);
        check("mid_rst_tx_data", 32'(tx_data), 32'h0);
        check("mid_rst_rdata", rdata, 32'h0);
        tick(2);
        reset = 1'b1;
        tick();
        rd_reg(ADDR_CON, d); check("con_after_mid_rst", d, 32'h08);
        tick(40);
        check("no_tx_after_rst", 32'(sent), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
